lamp_shifter: RTL and testbench
===============================

LAMP_SHIFTER -- requirements
Module: lamp_shifter

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per ser_clk half-period; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 lamps  input  16  lamp pattern from the upstream lamp sequencer, sampled on clk rising edge.
REQ-005 ser_data  output  1  serial lamp bit to external 16-bit shift-register chain.
REQ-006 ser_clk  output  1  shift clock to chain; the chain samples ser_data on the ser_clk rising edge.
REQ-007 ser_latch  output  1  storage-register latch pulse to chain, active-high.
REQ-008 busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-009 States SHALL be IDLE, SHIFT and LATCH, with all outputs registered.
REQ-010 IDLE: on a rising edge where lamps != shadow or pend_first == 1, the block SHALL copy lamps into shift_reg and shadow, clear pend_first, clear div_cnt and bit_cnt, and go to SHIFT.
REQ-011 IDLE with no trigger SHALL hold ser_clk=0, ser_latch=0 and busy=0.
REQ-012 SHIFT SHALL send 16 bits MSB first, lamps[15] first.
REQ-013 Each bit SHALL last 2*CLK_DIV cycles: ser_data valid with ser_clk=0 for CLK_DIV cycles, then ser_clk=1 for CLK_DIV cycles.
REQ-014 ser_data SHALL change only while ser_clk is 0.
REQ-015 After the 16th ser_clk high phase, the block SHALL drive ser_clk=0 and go to LATCH.
REQ-016 LATCH SHALL hold ser_latch=1 for CLK_DIV cycles, then return to IDLE with ser_latch=0.
REQ-017 Frame length SHALL be 33*CLK_DIV cycles from the capture edge to the return to IDLE; busy SHALL be high for exactly that span.
REQ-018 Changes on lamps during SHIFT or LATCH SHALL NOT alter the frame in flight.
REQ-019 Because shadow still holds the old value, the first IDLE cycle after such a change SHALL start a new frame (back-to-back frames, one IDLE cycle gap).
REQ-020 If lamps changes and returns to the shadow value during a frame, no extra frame SHALL be sent.
REQ-021 div_cnt SHALL be 8 bits and wrap at CLK_DIV-1.
REQ-022 bit_cnt SHALL be 4 bits and terminate at 15.
REQ-023 No state SHALL be unreachable; an illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-024 rst=1 SHALL immediately force: state=IDLE, ser_data=0, ser_clk=0, ser_latch=0, busy=0, shift_reg=0, shadow=0, counters=0, pend_first=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no latch pulse.
REQ-026 The first edge after rst deasserts SHALL start a full frame of the current lamps value, forced by pend_first.

Configuration
REQ-027 Macro LAMP_SHIFTER_INVERT_EN: when defined, ser_data SHALL be the complement of each lamp bit, for active-low lamp drivers.
REQ-028 Without LAMP_SHIFTER_INVERT_EN, ser_data SHALL be the true lamp bit.
REQ-029 Timing, ser_clk, ser_latch and the reset value ser_data=0 SHALL be unaffected by the macro.

Verification
REQ-030 Release rst with lamps=16'h0000, CLK_DIV=4 -> one frame of 16 zeros, ser_latch high 4 cycles, busy high 132 cycles, then idle.
REQ-031 lamps=16'h8001, CLK_DIV=2 -> bits sampled at ser_clk rises are 1, then 14 zeros, then 1; latch pulse 2 cycles wide.
REQ-032 lamps 16'h001F -> 16'h003F during bit 5 of a frame -> that frame sends 16'h001F; the next frame sends 16'h003F after one IDLE cycle.
REQ-033 rst pulse during bit 7 -> all outputs 0 in the same cycle, no latch pulse; after release, a full frame of the current lamps is sent.
REQ-034 LAMP_SHIFTER_INVERT_EN defined, lamps=16'hFFFF -> all 16 sampled bits are 0.
REQ-035 lamps held constant after a frame -> busy stays 0 and ser_clk shows no edges for 1000 cycles.

Source files
------------

// File: rtl/lamp_shifter.sv
// Serialises a 16-bit lamp pattern into an external shift-register chain, then latches it.
// Optional macro LAMP_SHIFTER_INVERT_EN drives complemented lamp bits for active-low drivers.
module lamp_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lamps,
  output logic        ser_data,
  output logic        ser_clk,
  output logic        ser_latch,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

`ifdef LAMP_SHIFTER_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [15:0] shift_reg, shift_reg_n;
  logic [15:0] shadow, shadow_n;
  logic [7:0]  div_cnt, div_cnt_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic        pend_first, pend_first_n;
  logic        ser_data_n, ser_clk_n, ser_latch_n, busy_n;

  // State and registered outputs; reset forces a full frame once released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= 16'h0000;
      shadow     <= 16'h0000;
      div_cnt    <= 8'd0;
      bit_cnt    <= 4'd0;
      pend_first <= 1'b1;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shift_reg  <= shift_reg_n;
      shadow     <= shadow_n;
      div_cnt    <= div_cnt_n;
      bit_cnt    <= bit_cnt_n;
      pend_first <= pend_first_n;
      ser_data   <= ser_data_n;
      ser_clk    <= ser_clk_n;
      ser_latch  <= ser_latch_n;
      busy       <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    shift_reg_n  = shift_reg;
    shadow_n     = shadow;
    div_cnt_n    = div_cnt;
    bit_cnt_n    = bit_cnt;
    pend_first_n = pend_first;
    ser_data_n   = ser_data;
    ser_clk_n    = ser_clk;
    ser_latch_n  = ser_latch;
    busy_n       = busy;
    case (state)
      IDLE: begin
        ser_clk_n   = 1'b0;
        ser_latch_n = 1'b0;
        busy_n      = 1'b0;
        if ((lamps != shadow) || pend_first) begin
          shift_reg_n  = lamps;
          shadow_n     = lamps;
          pend_first_n = 1'b0;
          div_cnt_n    = 8'd0;
          bit_cnt_n    = 4'd0;
          ser_data_n   = lamps[15] ^ INV;
          busy_n       = 1'b1;
          state_n      = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = 8'd0;
          if (!ser_clk) begin
            ser_clk_n = 1'b1;
          end else if (bit_cnt == 4'd15) begin
            ser_clk_n   = 1'b0;
            ser_latch_n = 1'b1;
            state_n     = LATCH;
          end else begin
            // Rotate so the next bit is always at [15]; new data only while ser_clk falls.
            bit_cnt_n   = bit_cnt + 4'd1;
            shift_reg_n = {shift_reg[14:0], shift_reg[15]};
            ser_data_n  = shift_reg[14] ^ INV;
            ser_clk_n   = 1'b0;
          end
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end
      LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n   = 8'd0;
          ser_latch_n = 1'b0;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end
      default: begin
        state_n     = IDLE;
        ser_clk_n   = 1'b0;
        ser_latch_n = 1'b0;
        busy_n      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lamp_shifter.sv
// Bench for lamp_shifter: two instances (CLK_DIV 4 and 2) share stimulus; per-instance
// monitors rebuild each shifted frame and compare it with a queue of expected frames.
module tb_lamp_shifter;

`ifdef LAMP_SHIFTER_INVERT_EN
  localparam logic [15:0] INVM = 16'hFFFF;
`else
  localparam logic [15:0] INVM = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lamps = 16'h0000;
  logic        sd [2];
  logic        sc [2];
  logic        sl [2];
  logic        bz [2];

  int total = 0;
  int bad   = 0;

  lamp_shifter #(.CLK_DIV(4)) u0 (
    .clk(clk), .rst(rst), .lamps(lamps),
    .ser_data(sd[0]), .ser_clk(sc[0]), .ser_latch(sl[0]), .busy(bz[0])
  );
  lamp_shifter #(.CLK_DIV(2)) u1 (
    .clk(clk), .rst(rst), .lamps(lamps),
    .ser_data(sd[1]), .ser_clk(sc[1]), .ser_latch(sl[1]), .busy(bz[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor state, one slot per instance.
  logic [15:0] word [2];
  logic [15:0] last_word [2];
  int          nb [2];
  int          lw [2];
  int          bw [2];
  logic        pc [2];
  logic        pd [2];
  logic        pl [2];
  logic        pb [2];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int          cd [2];
  initial begin
    cd[0] = 4;
    cd[1] = 2;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        word[i] <= 16'h0000; nb[i] <= 0; lw[i] <= 0; bw[i] <= 0;
        pc[i] <= 1'b0; pd[i] <= 1'b0; pl[i] <= 1'b0; pb[i] <= 1'b0;
      end else begin
        if (sc[i] && !pc[i]) begin
          word[i] <= {word[i][14:0], sd[i]};
          nb[i]   <= nb[i] + 1;
        end
        if (sc[i] && pc[i]) check($sformatf("data_stable_%0d", i), int'(sd[i]), int'(pd[i]));
        if (sl[i] && !pl[i]) begin
          logic [15:0] e;
          check($sformatf("bit_count_%0d", i), nb[i], 16);
          nb[i] <= 0;
          last_word[i] <= word[i];
          if (i == 0) begin
            if (q0.size() == 0) begin check("unexpected_frame_0", int'(word[i]), -1); e = 16'h0; end
            else begin e = q0.pop_front(); check("frame_0", int'(word[i]), int'(e)); end
          end else begin
            if (q1.size() == 0) begin check("unexpected_frame_1", int'(word[i]), -1); e = 16'h0; end
            else begin e = q1.pop_front(); check("frame_1", int'(word[i]), int'(e)); end
          end
        end
        if (sl[i]) lw[i] <= lw[i] + 1;
        if (!sl[i] && pl[i]) begin
          check($sformatf("latch_width_%0d", i), lw[i], cd[i]);
          lw[i] <= 0;
        end
        if (bz[i]) bw[i] <= bw[i] + 1;
        if (!bz[i] && pb[i]) begin
          check($sformatf("busy_width_%0d", i), bw[i], 33 * cd[i]);
          bw[i] <= 0;
        end
        pc[i] <= sc[i]; pd[i] <= sd[i]; pl[i] <= sl[i]; pb[i] <= bz[i];
      end
    end
  end

  task automatic push(input logic [15:0] v);
    q0.push_back(v ^ INVM);
    q1.push_back(v ^ INVM);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(posedge clk);
    while ((bz[0] || bz[1]) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic wait_busy0();
    int n = 0;
    while (!bz[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("busy_rise_timeout", n, 0);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_data_%0d", tag, i), int'(sd[i]), 0);
      check($sformatf("%s_clk_%0d", tag, i), int'(sc[i]), 0);
      check($sformatf("%s_latch_%0d", tag, i), int'(sl[i]), 0);
      check($sformatf("%s_busy_%0d", tag, i), int'(bz[i]), 0);
    end
  endtask

  typedef struct {
    logic [15:0] lamps;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int n;
    int edges;
    int busy_seen;
    tbl[0] = '{16'h8001, 16'h8001 ^ INVM};
    tbl[1] = '{16'hA5C3, 16'hA5C3 ^ INVM};
    tbl[2] = '{16'hFFFF, 16'hFFFF ^ INVM};
    tbl[3] = '{16'h0001, 16'h0001 ^ INVM};
    tbl[4] = '{16'h1234, 16'h1234 ^ INVM};
    tbl[5] = '{16'h8000, 16'h8000 ^ INVM};

    // Reset state, then the forced first frame of all zeros.
    repeat (3) @(negedge clk);
    check_zero("reset");
    push(16'h0000);
    rst = 1'b0;
    wait_idle();

    for (int k = 0; k < 6; k++) begin
      push(tbl[k].lamps);
      lamps = tbl[k].lamps;
      wait_idle();
      check($sformatf("vec%0d_word_0", k), int'(last_word[0]), int'(tbl[k].exp));
      check($sformatf("vec%0d_word_1", k), int'(last_word[1]), int'(tbl[k].exp));
    end

    // Change during bit 5: frame in flight unchanged, then one-cycle gap and new frame.
    push(16'h001F);
    push(16'h003F);
    lamps = 16'h001F;
    wait_busy0();
    repeat (42) @(negedge clk);
    lamps = 16'h003F;
    n = 0;
    while (bz[0] && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (!bz[0] && n < 10) begin @(negedge clk); n++; end
    check("idle_gap_0", n, 1);
    wait_idle();

    // Change and revert within a frame: no extra frame.
    push(16'h0F0F);
    lamps = 16'h0F0F;
    wait_busy0();
    repeat (20) @(negedge clk);
    lamps = 16'hFFFF;
    repeat (10) @(negedge clk);
    lamps = 16'h0F0F;
    wait_idle();

    // Reset during bit 7: immediate clear, aborted frame, full frame after release.
    lamps = 16'h3C3C;
    wait_busy0();
    repeat (58) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero("midrst");
    repeat (3) @(negedge clk);
    check_zero("midrst_hold");
    push(16'h3C3C);
    rst = 1'b0;
    wait_idle();

    // Quiet period with constant lamps.
    edges = 0;
    busy_seen = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (sc[0] || sc[1]) edges++;
      if (bz[0] || bz[1]) busy_seen++;
    end
    check("quiet_clk", edges, 0);
    check("quiet_busy", busy_seen, 0);
    check("queue_left_0", q0.size(), 0);
    check("queue_left_1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
